mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 30, word-line address width (128-bit line granularity).
REQ-002 Parameter: DATA_W, 128, line data width.
REQ-003 Parameter: STARVE_MAX, 4, consecutive D-side grants allowed while I-side waits.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 Port: reset  in  1  asynchronous, active-high reset.
REQ-007 Ports: ic_req_valid in 1, ic_req_addr in ADDR_W, ic_req_ready out 1  I-cache read request handshake.
REQ-008 Ports: ic_resp_valid out 1, ic_resp_data out DATA_W  I-cache read response, one-cycle pulse.
REQ-009 Ports: dc_req_valid in 1, dc_req_rw in 1 (1=write), dc_req_addr in ADDR_W, dc_req_data in DATA_W, dc_req_mask in DATA_W/8, dc_req_ready out 1  D-cache request handshake.
REQ-010 Ports: dc_resp_valid out 1, dc_resp_data out DATA_W  D-cache read data or write acknowledge, one-cycle pulse.
REQ-011 Ports: mem_req_valid out 1, mem_req_rw out 1, mem_req_addr out ADDR_W, mem_req_data out DATA_W, mem_req_mask out DATA_W/8, mem_req_ready in 1  main-memory request port.
REQ-012 Ports: mem_resp_valid in 1, mem_resp_data in DATA_W  main-memory read response.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE and WAIT; one transaction outstanding at most.
REQ-014 In IDLE, ic_req_ready/dc_req_ready SHALL be high only for the granted requester; the handshake fires when both valid and ready are high.
REQ-015 Grant: D-side wins when both are valid, except I-side wins when starve_cnt == STARVE_MAX.
REQ-016 starve_cnt SHALL increment on each D grant while ic_req_valid is high, saturate at STARVE_MAX, and clear on any I grant.
REQ-017 On grant, the block SHALL latch owner, rw, addr, data and mask, and enter ISSUE the next cycle.
REQ-018 In ISSUE, mem_req_valid SHALL be high with latched fields held stable until mem_req_ready is high.
REQ-019 On acceptance of a read, the FSM SHALL go to WAIT; on a write, it SHALL go to IDLE and pulse dc_resp_valid the next cycle with dc_resp_data = 0.
REQ-020 In WAIT, a mem_resp_valid SHALL register mem_resp_data and pulse the owner's resp_valid exactly one cycle later; then the FSM returns to IDLE.
REQ-021 mem_resp_valid outside WAIT SHALL be ignored.
REQ-022 Minimum read latency: grant cycle t -> mem_req_valid at t+1 -> with 0-cycle memory, resp at t+3.
REQ-023 An I-side write is impossible; ic requests are always reads (mem_req_rw = 0).
REQ-024 A new grant SHALL NOT occur in the same cycle that a response pulse is output; the next grant is possible in that IDLE cycle.

Reset
REQ-025 Reset SHALL force IDLE, starve_cnt = 0, and all outputs low (ready, valid, rw, data, mask, addr = 0).
REQ-026 Reset mid-transaction SHALL drop the transaction with no response pulse; a stale mem_resp_valid after reset SHALL be ignored.

Structure
REQ-027 State encoding, ADDR_W/DATA_W defaults and the rw encodings SHALL live in the shared constants package/header.
REQ-028 The grant/starvation logic SHALL be one sub-module, arb_prio (inputs: both valids and idle; outputs: grant_ic, grant_dc).

Verification
REQ-029 D read only: dc addr 0x10, memory returns 0xA5..A5 after 2 cycles -> dc_resp_valid one pulse with that data, ic_resp_valid never high.
REQ-030 Simultaneous ic/dc valid held high for 6 transactions -> grant order D,D,D,D,I,D with starve_cnt cleared after the I grant.
REQ-031 D write, mask 0x000F, mem_req_ready stalled 3 cycles -> mem_req fields stable for 4 cycles; dc_resp_valid pulses one cycle after acceptance.
REQ-032 Spurious mem_resp_valid in IDLE -> no response pulse and no state change.
REQ-033 Reset asserted in WAIT, then mem_resp_valid -> no resp pulse, outputs zero, next ic request served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the I/D memory arbiter.
// Holds the default widths, the starvation limit, the read/write encoding,
// the FSM state encoding and the transaction owner encoding.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF     = 30;   // word-line address (128-bit lines)
    localparam int DATA_W_DEF     = 128;  // line data width
    localparam int STARVE_MAX_DEF = 4;    // D grants allowed while I waits

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_IC = 1'b0,
        OWNER_DC = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Grant selection between the I-cache and D-cache request ports.
// D-side has priority, but after STARVE_MAX consecutive D grants taken while
// the I-side was waiting, the I-side wins the next arbitration.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   ic_valid, dc_valid  pending requests from each side
//   idle                arbiter may grant this cycle
//   grant_ic, grant_dc  one-hot (or zero) grant, combinational
module arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic ic_valid,
    input  logic dc_valid,
    input  logic idle,
    output logic grant_ic,
    output logic grant_dc
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_reg;
    logic [CNT_W-1:0] starve_cnt_next;
    logic             starved;

    assign starved  = (starve_cnt_reg == CNT_W'(STARVE_MAX));
    assign grant_ic = idle && ic_valid && (!dc_valid || starved);
    assign grant_dc = idle && dc_valid && !(ic_valid && starved);

    // Counts only D grants that bypassed a waiting I request; saturates.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (grant_ic) begin
            starve_cnt_next = '0;
        end else if (grant_dc && ic_valid && !starved) begin
            starve_cnt_next = starve_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache reads and D-cache reads/writes onto a single main-memory
// port with at most one transaction outstanding.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   ic_req_* / ic_resp_*             I-cache read request and response pulse
//   dc_req_* / dc_resp_*             D-cache request and response pulse
//                                    (write ack returns zero data)
//   mem_req_* / mem_resp_*           main-memory request and read response
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ic_req_valid,
    input  logic [ADDR_W-1:0]   ic_req_addr,
    output logic                ic_req_ready,
    output logic                ic_resp_valid,
    output logic [DATA_W-1:0]   ic_resp_data,
    input  logic                dc_req_valid,
    input  logic                dc_req_rw,
    input  logic [ADDR_W-1:0]   dc_req_addr,
    input  logic [DATA_W-1:0]   dc_req_data,
    input  logic [DATA_W/8-1:0] dc_req_mask,
    output logic                dc_req_ready,
    output logic                dc_resp_valid,
    output logic [DATA_W-1:0]   dc_resp_data,
    output logic                mem_req_valid,
    output logic                mem_req_rw,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_data,
    output logic [DATA_W/8-1:0] mem_req_mask,
    input  logic                mem_req_ready,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data
);

    localparam int MASK_W = DATA_W / 8;

    state_t              state_reg, state_next;
    owner_t              owner_reg;
    logic                rw_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   data_reg;
    logic [MASK_W-1:0]   mask_reg;
    logic                ic_resp_valid_reg, dc_resp_valid_reg;
    logic [DATA_W-1:0]   ic_resp_data_reg, dc_resp_data_reg;

    logic idle, grant_ic, grant_dc, write_accept, read_done;

    // No grant while a response pulse is on the outputs, and ready must stay
    // low for the whole time reset is asserted.
    assign idle = (state_reg == ST_IDLE) && !ic_resp_valid_reg
                  && !dc_resp_valid_reg && !reset;

    arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_arb_prio (
        .clk      (clk),
        .reset    (reset),
        .ic_valid (ic_req_valid),
        .dc_valid (dc_req_valid),
        .idle     (idle),
        .grant_ic (grant_ic),
        .grant_dc (grant_dc)
    );

    assign write_accept = (state_reg == ST_ISSUE) && mem_req_ready && (rw_reg == RW_WRITE);
    assign read_done    = (state_reg == ST_WAIT) && mem_resp_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (grant_ic || grant_dc) state_next = ST_ISSUE;
            ST_ISSUE: if (mem_req_ready) state_next = (rw_reg == RW_WRITE) ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (mem_resp_valid) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_reg         <= OWNER_IC;
            rw_reg            <= RW_READ;
            addr_reg          <= '0;
            data_reg          <= '0;
            mask_reg          <= '0;
            ic_resp_valid_reg <= 1'b0;
            dc_resp_valid_reg <= 1'b0;
            ic_resp_data_reg  <= '0;
            dc_resp_data_reg  <= '0;
        end else begin
            ic_resp_valid_reg <= 1'b0;
            dc_resp_valid_reg <= 1'b0;
            if (grant_ic) begin
                // I-side only ever reads; no write payload travels with it.
                owner_reg <= OWNER_IC;
                rw_reg    <= RW_READ;
                addr_reg  <= ic_req_addr;
                data_reg  <= '0;
                mask_reg  <= '0;
            end else if (grant_dc) begin
                owner_reg <= OWNER_DC;
                rw_reg    <= dc_req_rw;
                addr_reg  <= dc_req_addr;
                data_reg  <= dc_req_data;
                mask_reg  <= dc_req_mask;
            end
            if (write_accept) begin
                dc_resp_valid_reg <= 1'b1;
                dc_resp_data_reg  <= '0;
            end
            if (read_done) begin
                if (owner_reg == OWNER_IC) begin
                    ic_resp_valid_reg <= 1'b1;
                    ic_resp_data_reg  <= mem_resp_data;
                end else begin
                    dc_resp_valid_reg <= 1'b1;
                    dc_resp_data_reg  <= mem_resp_data;
                end
            end
        end
    end

    assign ic_req_ready  = grant_ic;
    assign dc_req_ready  = grant_dc;
    assign ic_resp_valid = ic_resp_valid_reg;
    assign ic_resp_data  = ic_resp_data_reg;
    assign dc_resp_valid = dc_resp_valid_reg;
    assign dc_resp_data  = dc_resp_data_reg;
    assign mem_req_valid = (state_reg == ST_ISSUE);
    assign mem_req_rw    = rw_reg;
    assign mem_req_addr  = addr_reg;
    assign mem_req_data  = data_reg;
    assign mem_req_mask  = mask_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level scoreboard tracks
// the single outstanding request, the starvation rule and the expected
// response pulse; directed sequences, a vector table and random traffic
// all run through the same per-cycle step.
module tb_mem_arbiter;

    localparam int AW = 30;
    localparam int DW = 128;
    localparam int MW = DW / 8;
    localparam int SMAX = 4;
    localparam int OWN_IC = 1;
    localparam int OWN_DC = 2;

    logic          clk, reset;
    logic          ic_req_valid, ic_req_ready, ic_resp_valid;
    logic [AW-1:0] ic_req_addr;
    logic [DW-1:0] ic_resp_data;
    logic          dc_req_valid, dc_req_rw, dc_req_ready, dc_resp_valid;
    logic [AW-1:0] dc_req_addr;
    logic [DW-1:0] dc_req_data, dc_resp_data;
    logic [MW-1:0] dc_req_mask;
    logic          mem_req_valid, mem_req_rw, mem_req_ready, mem_resp_valid;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data, mem_resp_data;
    logic [MW-1:0] mem_req_mask;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
        .dc_req_data(dc_req_data), .dc_req_mask(dc_req_mask), .dc_req_ready(dc_req_ready),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int txn_no = 0;

    // scoreboard: the one outstanding transaction and the pending response
    bit            m_txn, m_acc, m_pend;
    int            m_owner, m_powner, m_cnt;
    logic          m_rw;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_pdata;
    logic [MW-1:0] m_mask;

    // memory / requester behaviour knobs
    bit            mem_auto, rand_req, rand_ready, spur, lat_rand, mem_busy;
    int            mem_lat, mem_cd;
    logic [AW-1:0] mem_addr_q;

    int            grant_seen, resp_seen, mv_cnt;
    logic [DW-1:0] resp_data_seen;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return {4{{2'b01, a}}};
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        logic [31:0] r;
        r = $urandom();
        return r[AW-1:0];
    endfunction

    function automatic logic [MW-1:0] rnd_mask();
        logic [31:0] r;
        r = $urandom();
        return r[MW-1:0];
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic sample_model();
        logic g_ic, g_dc;
        bit   pend_n;
        if (mem_req_valid) mv_cnt++;
        grant_seen = 0;
        resp_seen  = 0;
        if (reset) begin
            chk("rst_ctrl", {ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid,
                             mem_req_valid, mem_req_rw}, 0);
            chk("rst_addr", mem_req_addr, 0);
            chk("rst_wdata", mem_req_data, 0);
            chk("rst_mask", mem_req_mask, 0);
            chk("rst_rdata", {ic_resp_data, dc_resp_data}, 0);
            m_txn = 0; m_acc = 0; m_pend = 0; m_cnt = 0; mem_busy = 0;
            return;
        end
        chk("ic_resp_valid", ic_resp_valid, m_pend && m_powner == OWN_IC);
        chk("dc_resp_valid", dc_resp_valid, m_pend && m_powner == OWN_DC);
        if (m_pend) begin
            resp_seen      = m_powner;
            resp_data_seen = (m_powner == OWN_IC) ? ic_resp_data : dc_resp_data;
            chk("resp_data", resp_data_seen, m_pdata);
            txn_no++;
            $display("txn %0d: %s response data=%h at cycle %0d", txn_no,
                     (m_powner == OWN_IC) ? "ic" : "dc", resp_data_seen, cyc);
        end
        g_ic = !m_txn && !m_pend && ic_req_valid && (!dc_req_valid || m_cnt == SMAX);
        g_dc = !m_txn && !m_pend && dc_req_valid && !g_ic;
        chk("ic_req_ready", ic_req_ready, g_ic);
        chk("dc_req_ready", dc_req_ready, g_dc);
        chk("mem_req_valid", mem_req_valid, m_txn && !m_acc);
        if (m_txn && !m_acc)
            chk("mem_req_fields", {mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask},
                {m_rw, m_addr, m_data, m_mask});
        pend_n = 0;
        if (m_txn && !m_acc && mem_req_ready) begin
            m_acc = 1;
            if (m_rw) begin
                pend_n = 1; m_powner = OWN_DC; m_pdata = '0; m_txn = 0;
            end else if (mem_auto) begin
                mem_busy = 1;
                mem_cd = lat_rand ? $urandom_range(3) : mem_lat;
                mem_addr_q = m_addr;
            end
        end else if (m_txn && m_acc && mem_resp_valid) begin
            pend_n = 1; m_powner = m_owner; m_pdata = mem_resp_data; m_txn = 0;
        end
        if (g_ic) begin
            m_txn = 1; m_acc = 0; m_owner = OWN_IC; m_rw = 0;
            m_addr = ic_req_addr; m_data = '0; m_mask = '0;
            m_cnt = 0; grant_seen = OWN_IC;
        end
        if (g_dc) begin
            m_txn = 1; m_acc = 0; m_owner = OWN_DC; m_rw = dc_req_rw;
            m_addr = dc_req_addr; m_data = dc_req_data; m_mask = dc_req_mask;
            if (ic_req_valid && m_cnt < SMAX) m_cnt++;
            grant_seen = OWN_DC;
        end
        m_pend = pend_n;
    endtask

    task automatic post_edge();
        if (mem_auto) begin
            mem_resp_valid = 1'b0;
            if (mem_busy) begin
                if (mem_cd == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_fn(mem_addr_q);
                    mem_busy = 0;
                end else begin
                    mem_cd--;
                end
            end else if (spur && $urandom_range(7) == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = rnd_data();
            end
            mem_req_ready = rand_ready ? ($urandom_range(1) == 1) : 1'b1;
        end
        if (rand_req) begin
            if (grant_seen == OWN_IC) ic_req_valid = 1'b0;
            if (grant_seen == OWN_DC) dc_req_valid = 1'b0;
            if (!ic_req_valid && $urandom_range(2) == 0) begin
                ic_req_valid = 1'b1; ic_req_addr = rnd_addr();
            end
            if (!dc_req_valid && $urandom_range(2) == 0) begin
                dc_req_valid = 1'b1; dc_req_rw = ($urandom_range(1) == 1);
                dc_req_addr = rnd_addr(); dc_req_data = rnd_data(); dc_req_mask = rnd_mask();
            end
        end
    endtask

    // Called at posedge+1 with inputs settled; samples at posedge+2, then
    // returns at posedge+1 of the next cycle.
    task automatic step();
        #1;
        sample_model();
        @(posedge clk);
        #1;
        cyc++;
        post_edge();
    endtask

    task automatic wait_grant(output int who);
        who = 0;
        for (int k = 0; k < 20 && who == 0; k++) begin
            step();
            who = grant_seen;
        end
        if (who == 0) chk("grant_timeout", 0, 1);
    endtask

    task automatic wait_resp(output int who);
        who = 0;
        for (int k = 0; k < 30 && who == 0; k++) begin
            step();
            who = resp_seen;
        end
        if (who == 0) chk("resp_timeout", 0, 1);
    endtask

    typedef struct {
        bit ic_v;
        bit dc_v;
        bit dc_rw;
        int exp_grant;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int who, who2, t0, sp;
        logic [DW-1:0] exp_d;

        vecs[0] = '{1, 1, 0, OWN_DC};
        vecs[1] = '{1, 1, 1, OWN_DC};
        vecs[2] = '{1, 1, 0, OWN_DC};
        vecs[3] = '{1, 1, 0, OWN_DC};
        vecs[4] = '{1, 1, 0, OWN_IC};
        vecs[5] = '{1, 1, 1, OWN_DC};
        vecs[6] = '{1, 0, 0, OWN_IC};
        vecs[7] = '{0, 1, 1, OWN_DC};
        vecs[8] = '{0, 1, 0, OWN_DC};
        vecs[9] = '{1, 1, 0, OWN_DC};

        reset = 1'b1;
        ic_req_valid = 0; ic_req_addr = '0;
        dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0; dc_req_data = '0; dc_req_mask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        mem_auto = 0; rand_req = 0; rand_ready = 0; spur = 0; lat_rand = 0; mem_lat = 1;
        @(posedge clk);
        #1;
        ic_req_valid = 1'b1;              // ready must stay low under reset
        step();
        ic_req_valid = 1'b0;
        step();
        reset = 1'b0;
        step();

        // Vector table: both valids held across the first six transactions.
        mem_auto = 1; mem_lat = 1; mem_req_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ic_req_valid = vecs[i].ic_v; ic_req_addr = AW'(32'h100 + i);
            dc_req_valid = vecs[i].dc_v; dc_req_rw = vecs[i].dc_rw;
            dc_req_addr = AW'(32'h200 + i); dc_req_data = rnd_data(); dc_req_mask = rnd_mask();
            wait_grant(who);
            chk($sformatf("vec%0d_grant", i), who, vecs[i].exp_grant);
            wait_resp(who2);
            chk($sformatf("vec%0d_resp_owner", i), who2, vecs[i].exp_grant);
            if (vecs[i].exp_grant == OWN_IC) exp_d = mem_fn(AW'(32'h100 + i));
            else if (vecs[i].dc_rw) exp_d = '0;
            else exp_d = mem_fn(AW'(32'h200 + i));
            chk($sformatf("vec%0d_resp_data", i), resp_data_seen, exp_d);
        end
        ic_req_valid = 0; dc_req_valid = 0;
        step();

        // Minimum read latency with a zero-cycle memory.
        mem_lat = 0;
        ic_req_valid = 1'b1; ic_req_addr = AW'(32'h3C);
        wait_grant(who);
        t0 = cyc;
        ic_req_valid = 1'b0;
        wait_resp(who2);
        chk("min_latency", cyc - t0, 3);

        // D read of 0x10, memory answers after two WAIT cycles.
        mem_auto = 0; mem_req_ready = 0; mem_resp_valid = 0;
        step();
        dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = AW'(32'h10);
        step();
        chk("dread_grant", grant_seen, OWN_DC);
        dc_req_valid = 1'b0; mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        step();
        mem_resp_valid = 1'b1; mem_resp_data = {16{8'hA5}};
        step();
        mem_resp_valid = 1'b0;
        step();
        chk("dread_resp_owner", resp_seen, OWN_DC);
        chk("dread_resp_data", resp_data_seen, {16{8'hA5}});

        // D write with mask 0x000F, memory stalls acceptance for 3 cycles.
        dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = AW'(32'h33);
        dc_req_data = rnd_data(); dc_req_mask = MW'(16'h000F);
        step();
        chk("dwrite_grant", grant_seen, OWN_DC);
        dc_req_valid = 1'b0; mv_cnt = 0;
        repeat (3) step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        chk("dwrite_valid_cycles", mv_cnt, 4);
        chk("dwrite_ack_owner", resp_seen, OWN_DC);
        chk("dwrite_ack_data", resp_data_seen, 0);

        // Spurious memory response while idle.
        mem_resp_valid = 1'b1; mem_resp_data = rnd_data();
        step();
        mem_resp_valid = 1'b0;
        sp = 0;
        repeat (3) begin
            step();
            if (resp_seen != 0) sp++;
        end
        chk("spurious_pulses", sp, 0);
        ic_req_valid = 1'b1; ic_req_addr = AW'(32'h55);
        step();
        chk("spurious_then_grant", grant_seen, OWN_IC);
        ic_req_valid = 1'b0; mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = mem_fn(AW'(32'h55));
        step();
        mem_resp_valid = 1'b0;
        step();
        chk("spurious_then_resp", resp_seen, OWN_IC);

        // Reset while waiting for read data, then a stale response.
        ic_req_valid = 1'b1; ic_req_addr = AW'(32'h77);
        step();
        ic_req_valid = 1'b0; mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = rnd_data();
        step();
        mem_resp_valid = 1'b0;
        sp = 0;
        repeat (3) begin
            step();
            if (resp_seen != 0) sp++;
        end
        chk("reset_drop_pulses", sp, 0);
        mem_auto = 1; mem_lat = 2; mem_req_ready = 1'b1;
        ic_req_valid = 1'b1; ic_req_addr = AW'(32'h78);
        wait_grant(who);
        chk("post_reset_grant", who, OWN_IC);
        ic_req_valid = 1'b0;
        wait_resp(who2);
        chk("post_reset_resp", who2, OWN_IC);
        chk("post_reset_data", resp_data_seen, mem_fn(AW'(32'h78)));

        // Random traffic against the scoreboard.
        rand_ready = 1; spur = 1; lat_rand = 1; rand_req = 1;
        repeat (800) step();
        rand_req = 0; ic_req_valid = 0; dc_req_valid = 0;
        repeat (30) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
